// File: rtl/serial_digit_adder_pkg.sv
// Shared types and constants for the serial digit adder.
// Default widths, FSM encoding and the counter-width helper.
package adder_pkg;

    localparam int DEF_WIDTH = 20;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A 1-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Operand/result handshake bundle for serial_digit_adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag.
interface serial_digit_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, i0, i1, cin, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef SERIAL_ADDER_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, i0, i1, cin, out_ready,
        output in_ready, out_valid, s, cout
`ifdef SERIAL_ADDER_OVF_EN
        , ovf
`endif
    );

endinterface

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational W-bit ripple adder built from full_adder cells.
// c_msb_in exposes the carry into the top bit for overflow detection.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb_in
);
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar g = 0; g < W; g++) begin : g_fa
        full_adder u_fa (
            .a  (a[g]),
            .b  (b[g]),
            .ci (w_c[g]),
            .s  (sum[g]),
            .co (w_c[g+1])
        );
    end

    assign co       = w_c[W];
    assign c_msb_in = w_c[W-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: one DIGIT-wide slice reused NDIG times per operation.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_digit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_digit_adder_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    state_t           r_state;
    logic [WIDTH-1:0] r_op0;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic [DIGIT-1:0] w_sum;
    logic             w_co;
    logic             w_cmsb;
    logic             w_last;

    digit_adder #(.W(DIGIT)) u_digit (
        .a        (r_op0[DIGIT-1:0]),
        .b        (r_op1[DIGIT-1:0]),
        .ci       (r_carry),
        .sum      (w_sum),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    assign w_last = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op0       <= '0;
            r_op1       <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op0      <= bus.i0;
                        r_op1      <= bus.i1;
                        r_carry    <= bus.cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Digits enter at the MSB end so the sum is aligned after NDIG shifts.
                    r_res   <= {w_sum, r_res[WIDTH-1:DIGIT]};
                    r_op0   <= r_op0 >> DIGIT;
                    r_op1   <= r_op1 >> DIGIT;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf       <= w_cmsb ^ w_co;
`endif
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_ADDER_OVF_EN
    logic w_unused;
    assign w_unused = w_cmsb;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_res;
    assign bus.cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_digit_adder.sv
// Randomized bench for serial_digit_adder against an arithmetic model.
// Build with SERIAL_ADDER_OVF_EN to also check the overflow flag.
module tb_serial_digit_adder;
    import adder_pkg::*;

    localparam int W    = 20;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_bad;

    serial_digit_adder_if #(.WIDTH(W)) bus ();

    serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_s"}, 32'(bus.s), 32'd0);
        chk({tag, "_cout"}, 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    // Present operands in IDLE; return after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.i0       = a;
        bus.i1       = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.i0       = W'($urandom);
        bus.i1       = W'($urandom);
        bus.cin      = 1'($urandom);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input int stall, input bit junk);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int           k;
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        launch(a, b, c);
        k = 0;
        while (!bus.out_valid && k < 4 * NDIG) begin
            // Busy-time in_valid and early out_ready must both be ignored.
            if (junk && k == 1) begin
                bus.in_valid  = 1'b1;
                bus.i0        = 20'h11111;
                bus.out_ready = 1'b1;
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
            if (!bus.out_valid)
                chk("run_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("latency", 32'(k), 32'(NDIG));
        chk("sum", 32'(bus.s), 32'(exp[W-1:0]));
        chk("cout", 32'(bus.cout), 32'(exp[W]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 32'(bus.ovf),
            32'((a[W-1] == b[W-1]) && (exp[W-1] != a[W-1])));
`endif
        held = bus.s;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_sum", 32'(bus.s), 32'(held));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("drop_valid", 32'(bus.out_valid), 32'd0);
        chk("back_idle", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_tot         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.i0        = '0;
        bus.i1        = '0;
        bus.cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run(20'h12345, 20'h0ABCD, 1'b0, 0, 1'b0);
        run(20'hFFFFF, 20'h00001, 1'b0, 0, 1'b0);
        run(20'h00000, 20'h00000, 1'b1, 0, 1'b0);
        run(20'h00010, 20'h00020, 1'b0, 10, 1'b1);
        run(20'h7FFFF, 20'h00001, 1'b0, 1, 1'b0);
        run(20'hFFFFF, 20'hFFFFF, 1'b1, 0, 1'b0);
        run(20'h80000, 20'h80000, 1'b0, 2, 1'b1);

        // Abort during the third RUN cycle; reset must act before any edge.
        launch(20'h54321, 20'h12345, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run(20'h00002, 20'h00003, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run(W'($urandom), W'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Multi-cycle adder for the ALU datapath; companion to the 20-bit ripple subtractor.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one shared DIGIT-bit ripple adder slice.
- Uses valid/ready handshakes on both input and output, so the ALU sequencer can stall it.

Parameters:
- WIDTH, 20, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; NDIG = WIDTH/DIGIT (default 5).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- i0  input  WIDTH  augend
- i1  input  WIDTH  addend
- cin  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum
- cout  output  1  carry-out of MSB

Behaviour:
- Reset values (asserted asynchronously whenever rst_n=0): state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, digit counter=0, internal carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1 at a rising edge:
  - latch i0, i1 into shift registers;
  - latch cin as carry;
  - clear the counter;
  - go to RUN.
- RUN: in_ready=0. Each cycle:
  - add the low DIGIT bits of both shift registers plus carry;
  - shift the DIGIT-bit sum into the MSB end of the result register;
  - shift the operands right by DIGIT;
  - update carry and increment the counter.
  - After the NDIG-th digit (counter==NDIG-1), go to DONE.
- DONE: out_valid=1, s=full sum, cout=final carry. Hold s/cout stable until out_ready=1. On that edge, drop out_valid and return to IDLE.
- Latency: in_valid accepted at edge N → out_valid high after edge N+NDIG (5 cycles at defaults).
- No overlap: the next operand can be accepted at the earliest one cycle after the output handshake, so maximum throughput is 1 op per NDIG+2 cycles.
- in_valid while not IDLE is ignored; operands must be held by the source until in_ready is seen.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of i0+i1+cin.
- Wrap-around example: 0xFFFFF+0x00001 gives s=0x00000, cout=1.
- out_ready asserted outside DONE has no effect.
- Reset mid-RUN or mid-DONE aborts immediately: the result is discarded and the block is in IDLE on the first edge after rst_n rises.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - adds output ovf (1 bit, reset 0);
  - ovf = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB, captured on the final RUN digit;
  - ovf is valid with out_valid and held in DONE.
- When undefined: port absent, no extra logic.

Decomposition:
- Package adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH/DIGIT;
  - the counter-width function clog2(NDIG).
- Sub-module digit_adder: combinational DIGIT-bit ripple of full_adder cells.
  - Inputs a, b, ci; outputs sum, co, and c_msb_in (carry into top bit, used by SERIAL_ADDER_OVF_EN).
- The top level holds only the FSM, shift registers, counter and carry flop.

Test Plan:
- Basic add: i0=0x12345, i1=0x0ABCD, cin=0 → out_valid after 5 cycles; s=0x1CF12, cout=0.
- Carry-in and wrap: i0=0xFFFFF, i1=0x00001, cin=0 → s=0x00000, cout=1. Then i0=0, i1=0, cin=1 → s=0x00001, cout=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid → s/out_valid held constant, in_ready=0 throughout. out_ready=1 → IDLE next cycle.
- Busy rejection: in_valid pulsed with i0=0x11111 during RUN of 0x00010+0x00020 → ignored; s=0x00030.
- Reset mid-operation: drop rst_n on the 3rd RUN cycle → outputs go to reset values asynchronously, before the next edge. After release, a new add 0x00002+0x00003 gives s=0x00005.
- Overflow (SERIAL_ADDER_OVF_EN): 0x7FFFF+0x00001 → s=0x80000, ovf=1, cout=0. 0xFFFFF+0x00001 → ovf=0, cout=1.
